// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage data-access unit of the 5-stage MIPS pipeline. It owns the
//   data memory (DM_WORDS x 32 bit, byte range 0 .. 4*DM_WORDS-1). It decodes
//   the M-stage load/store into a DM or device-bus access, produces the
//   extended load result for MEM/WB, and flags AdEL/AdES.
//   Loads are combinational. Stores commit at the next posedge of clk.
//
// Ports
//   clk        in   1  clock
//   reset      in   1  synchronous, active-high; clears every DM word
//   mem_op     in   4  0 none,1 lw,2 lh,3 lhu,4 lb,5 lbu,6 sw,7 sh,8 sb (9-15 none)
//   addr       in  32  effective address
//   wdata      in  32  store data (forwarded rt)
//   kill       in   1  flush of this M instruction; suppresses every write
//   rdata      out 32  extended load result (0 when not a load or on AdEL)
//   exc_adel   out  1  load address error
//   exc_ades   out  1  store address error
//   dev_addr   out 32  device address (= addr)
//   dev_wdata  out 32  device write data (= wdata)
//   dev_we     out  1  device write strobe
//   dev_rdata  in  32  device read data, combinational

module mem_access_unit #(
  parameter int unsigned DM_WORDS  = 3072,
  parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7F10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        kill,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic        dev_we,
  input  logic [31:0] dev_rdata
);

  localparam int unsigned AW       = $clog2(DM_WORDS);
  localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  logic [31:0] r_dm [DM_WORDS];

  // ---------------------------------------------------------------- op decode
  logic  w_is_load;
  logic  w_is_store;
  logic  w_sext;
  size_e w_size;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_sext     = 1'b0;
    w_size     = SZ_WORD;
    case (mem_op)
      OP_LW:  begin w_is_load  = 1'b1; w_size = SZ_WORD;                end
      OP_LH:  begin w_is_load  = 1'b1; w_size = SZ_HALF; w_sext = 1'b1; end
      OP_LHU: begin w_is_load  = 1'b1; w_size = SZ_HALF;                end
      OP_LB:  begin w_is_load  = 1'b1; w_size = SZ_BYTE; w_sext = 1'b1; end
      OP_LBU: begin w_is_load  = 1'b1; w_size = SZ_BYTE;                end
      OP_SW:  begin w_is_store = 1'b1; w_size = SZ_WORD;                end
      OP_SH:  begin w_is_store = 1'b1; w_size = SZ_HALF;                end
      OP_SB:  begin w_is_store = 1'b1; w_size = SZ_BYTE;                end
      default: ;
    endcase
  end

  // ------------------------------------------------------------ region decode
  logic          w_in_dm;
  logic          w_in_dev0;
  logic          w_in_dev1;
  logic          w_in_dev;
  logic          w_mapped;
  logic [3:0]    w_dev_off;
  logic          w_dev_count;
  logic          w_misalign;
  logic [AW-1:0] w_idx;

  assign w_in_dm   = (addr < DM_BYTES);
  assign w_in_dev0 = (addr >= DEV0_BASE) && (addr <= DEV0_BASE + 32'hB);
  assign w_in_dev1 = (addr >= DEV1_BASE) && (addr <= DEV1_BASE + 32'hB);
  assign w_in_dev  = w_in_dev0 | w_in_dev1;
  assign w_mapped  = w_in_dm | w_in_dev;
  assign w_idx     = addr[AW+1:2];

  // Each device window is 12 bytes, so the low nibble of the difference is
  // the full offset; word offset 0x8 is the read-only Count register.
  assign w_dev_off   = addr[3:0] - (w_in_dev0 ? DEV0_BASE[3:0] : DEV1_BASE[3:0]);
  assign w_dev_count = w_in_dev && (w_dev_off[3:2] == 2'b10);

  assign w_misalign = ((w_size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                      ((w_size == SZ_HALF) && addr[0]);

  // --------------------------------------------------------------- exceptions
  assign exc_adel = w_is_load &&
                    (w_misalign || !w_mapped || (w_in_dev && (w_size != SZ_WORD)));

  assign exc_ades = w_is_store &&
                    (w_misalign || !w_mapped || (w_in_dev && (w_size != SZ_WORD)) ||
                     w_dev_count);

  // ----------------------------------------------------------- store control
  logic       w_we;
  logic       w_dm_we;
  logic [3:0] w_be;
  logic [31:0] w_wlane;

  assign w_we    = w_is_store && !exc_ades && !kill && !reset;
  assign w_dm_we = w_we && w_in_dm;

  assign dev_we    = w_we && w_in_dev;
  assign dev_addr  = addr;
  assign dev_wdata = wdata;

  // Store data is replicated across lanes so each byte enable can pick its
  // lane from the same bit position it will be written to.
  always_comb begin
    w_be    = '0;
    w_wlane = wdata;
    case (w_size)
      SZ_WORD: begin
        w_be    = 4'b1111;
        w_wlane = wdata;
      end
      SZ_HALF: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{wdata[15:0]}};
      end
      SZ_BYTE: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wlane = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) begin
        r_dm[i] <= '0;
      end
    end else if (w_dm_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_dm[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------- load path
  logic [31:0] w_word;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_ext;

  // The DM index is only meaningful inside the DM window; addresses between
  // the DM top and the index wrap-around would otherwise read past the array.
  assign w_word = w_in_dev ? dev_rdata : (w_in_dm ? r_dm[w_idx] : '0);
  assign w_half = addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_byte = w_word[8*addr[1:0] +: 8];

  always_comb begin
    w_ext = '0;
    case (w_size)
      SZ_WORD: w_ext = w_word;
      SZ_HALF: w_ext = {{16{w_sext & w_half[15]}}, w_half};
      SZ_BYTE: w_ext = {{24{w_sext & w_byte[7]}}, w_byte};
      default: ;
    endcase
  end

  assign rdata = (w_is_load && !exc_adel) ? w_ext : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        kill;
  logic [31:0] rdata;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] dev_addr;
  logic [31:0] dev_wdata;
  logic        dev_we;
  logic [31:0] dev_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DM_WORDS (3072),
    .DEV0_BASE(32'h0000_7F00),
    .DEV1_BASE(32'h0000_7F10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_op   (mem_op),
    .addr     (addr),
    .wdata    (wdata),
    .kill     (kill),
    .rdata    (rdata),
    .exc_adel (exc_adel),
    .exc_ades (exc_ades),
    .dev_addr (dev_addr),
    .dev_wdata(dev_wdata),
    .dev_we   (dev_we),
    .dev_rdata(dev_rdata)
  );

  localparam logic [3:0] NONE = 4'd0, LW = 4'd1, LH = 4'd2, LHU = 4'd3, LB = 4'd4,
                         LBU = 4'd5, SW = 4'd6, SH = 4'd7, SB = 4'd8;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic        dwe;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: the unit is combinational, so each issued op presents its
  // response in the same cycle; compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (rdata !== e.rdata) begin
        bad++;
        $display("FAIL %s rdata: got %h want %h", e.name, rdata, e.rdata);
      end
      total++;
      if (exc_adel !== e.adel) begin
        bad++;
        $display("FAIL %s exc_adel: got %b want %b", e.name, exc_adel, e.adel);
      end
      total++;
      if (exc_ades !== e.ades) begin
        bad++;
        $display("FAIL %s exc_ades: got %b want %b", e.name, exc_ades, e.ades);
      end
      total++;
      if (dev_we !== e.dwe) begin
        bad++;
        $display("FAIL %s dev_we: got %b want %b", e.name, dev_we, e.dwe);
      end
      total++;
      if (dev_addr !== e.addr || dev_wdata !== e.wdata) begin
        bad++;
        $display("FAIL %s dev bus: got %h/%h want %h/%h", e.name, dev_addr, dev_wdata,
                 e.addr, e.wdata);
      end
    end
  end

  // Drive one op for one cycle and post its expected response.
  task automatic op(input string name, input logic [3:0] o, input logic [31:0] a,
                    input logic [31:0] wd, input logic k, input logic rst,
                    input logic [31:0] drd, input logic [31:0] exp_rd,
                    input logic exp_adel, input logic exp_ades, input logic exp_dwe);
    exp_t e;
    @(posedge clk);
    #1;
    mem_op    = o;
    addr      = a;
    wdata     = wd;
    kill      = k;
    reset     = rst;
    dev_rdata = drd;
    e.name  = name;
    e.addr  = a;
    e.wdata = wd;
    e.rdata = exp_rd;
    e.adel  = exp_adel;
    e.ades  = exp_ades;
    e.dwe   = exp_dwe;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; mem_op = NONE; addr = '0; wdata = '0; kill = 1'b0; dev_rdata = '0;

    //   name            op    addr          wdata         kill rst  dev_rdata     rdata         adel ades dwe
    op("rst_none",     NONE, 32'h0,        32'h0,        0, 1, 32'h0,        32'h0,        0, 0, 0);
    op("rst_lw0",      LW,   32'h0,        32'h0,        0, 1, 32'h0,        32'h0,        0, 0, 0);
    op("rst_lw1_adel", LW,   32'h1,        32'h0,        0, 1, 32'h0,        32'h0,        1, 0, 0);
    op("rst_sw_dev",   SW,   32'h7F04,     32'h1,        0, 1, 32'h0,        32'h0,        0, 0, 0);
    op("sw0",          SW,   32'h0,        32'h12345678, 0, 0, 32'h0,        32'h0,        0, 0, 0);
    op("lw0",          LW,   32'h0,        32'h0,        0, 0, 32'h0,        32'h12345678, 0, 0, 0);
    op("lb3",          LB,   32'h3,        32'h0,        0, 0, 32'h0,        32'h00000012, 0, 0, 0);
    op("lbu1",         LBU,  32'h1,        32'h0,        0, 0, 32'h0,        32'h00000056, 0, 0, 0);
    op("sb2",          SB,   32'h2,        32'h80,       0, 0, 32'h0,        32'h0,        0, 0, 0);
    op("lb2",          LB,   32'h2,        32'h0,        0, 0, 32'h0,        32'hFFFFFF80, 0, 0, 0);
    op("lw0_sb",       LW,   32'h0,        32'h0,        0, 0, 32'h0,        32'h12805678, 0, 0, 0);
    op("sh2",          SH,   32'h2,        32'hBEEF,     0, 0, 32'h0,        32'h0,        0, 0, 0);
    op("lh2",          LH,   32'h2,        32'h0,        0, 0, 32'h0,        32'hFFFFBEEF, 0, 0, 0);
    op("lhu2",         LHU,  32'h2,        32'h0,        0, 0, 32'h0,        32'h0000BEEF, 0, 0, 0);
    op("lw0_sh",       LW,   32'h0,        32'h0,        0, 0, 32'h0,        32'hBEEF5678, 0, 0, 0);
    op("lw1_adel",     LW,   32'h1,        32'h0,        0, 0, 32'h0,        32'h0,        1, 0, 0);
    op("sw3000_ades",  SW,   32'h3000,     32'hDEAD,     0, 0, 32'h0,        32'h0,        0, 1, 0);
    op("lw0_after3000",LW,   32'h0,        32'h0,        0, 0, 32'h0,        32'hBEEF5678, 0, 0, 0);
    op("sw7F08_ades",  SW,   32'h7F08,     32'h9,        0, 0, 32'h0,        32'h0,        0, 1, 0);
    op("lb7F00_adel",  LB,   32'h7F00,     32'h0,        0, 0, 32'h11,       32'h0,        1, 0, 0);
    op("sw7F04_dev",   SW,   32'h7F04,     32'h9,        0, 0, 32'h0,        32'h0,        0, 0, 1);
    op("idle7F04",     NONE, 32'h7F04,     32'h9,        0, 0, 32'h0,        32'h0,        0, 0, 0);
    op("lw7F14_dev",   LW,   32'h7F14,     32'h0,        0, 0, 32'hA5,       32'h000000A5, 0, 0, 0);
    op("lw7F10_dev",   LW,   32'h7F10,     32'h0,        0, 0, 32'h80000000, 32'h80000000, 0, 0, 0);
    op("lw7F08_count", LW,   32'h7F08,     32'h0,        0, 0, 32'h5,        32'h00000005, 0, 0, 0);
    op("lh7F10_adel",  LH,   32'h7F10,     32'h0,        0, 0, 32'h1234,     32'h0,        1, 0, 0);
    op("sh7F04_ades",  SH,   32'h7F04,     32'h1,        0, 0, 32'h0,        32'h0,        0, 1, 0);
    op("sw2FFC",       SW,   32'h2FFC,     32'h11223344, 0, 0, 32'h0,        32'h0,        0, 0, 0);
    op("lw2FFC",       LW,   32'h2FFC,     32'h0,        0, 0, 32'h0,        32'h11223344, 0, 0, 0);
    op("sw2FFC_kill",  SW,   32'h2FFC,     32'hFFFFFFFF, 1, 0, 32'h0,        32'h0,        0, 0, 0);
    op("lw2FFC_kept",  LW,   32'h2FFC,     32'h0,        0, 0, 32'h0,        32'h11223344, 0, 0, 0);
    op("swdev_kill",   SW,   32'h7F04,     32'h3,        1, 0, 32'h0,        32'h0,        0, 0, 0);
    op("lw3000_adel",  LW,   32'h3000,     32'h0,        0, 0, 32'h0,        32'h0,        1, 0, 0);
    op("lw7F0C_adel",  LW,   32'h7F0C,     32'h0,        0, 0, 32'h77,       32'h0,        1, 0, 0);
    op("sh1_ades",     SH,   32'h1,        32'h1,        0, 0, 32'h0,        32'h0,        0, 1, 0);
    op("lhu3_adel",    LHU,  32'h3,        32'h0,        0, 0, 32'h0,        32'h0,        1, 0, 0);
    op("op9_none",     4'd9, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0);
    op("op15_none",    4'd15,32'h1,        32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0);
    op("sw2FFC_rst",   SW,   32'h2FFC,     32'hCAFEF00D, 0, 1, 32'h0,        32'h0,        0, 0, 0);
    op("lw2FFC_zero",  LW,   32'h2FFC,     32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0);
    op("lw0_zero",     LW,   32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0);
    op("sb2FFF",       SB,   32'h2FFF,     32'h123456AB, 0, 0, 32'h0,        32'h0,        0, 0, 0);
    op("lbu2FFF",      LBU,  32'h2FFF,     32'h0,        0, 0, 32'h0,        32'h000000AB, 0, 0, 0);
    op("lw2FFC_sb",    LW,   32'h2FFC,     32'h0,        0, 0, 32'h0,        32'hAB000000, 0, 0, 0);
    op("sb1",          SB,   32'h1,        32'hC3,       0, 0, 32'h0,        32'h0,        0, 0, 0);
    op("lb1",          LB,   32'h1,        32'h0,        0, 0, 32'h0,        32'hFFFFFFC3, 0, 0, 0);
    op("sh0",          SH,   32'h0,        32'hAAAA7FFF, 0, 0, 32'h0,        32'h0,        0, 0, 0);
    op("lh0",          LH,   32'h0,        32'h0,        0, 0, 32'h0,        32'h00007FFF, 0, 0, 0);
    op("lw0_final",    LW,   32'h0,        32'h0,        0, 0, 32'h0,        32'h00007FFF, 0, 0, 0);

    @(posedge clk);
    #1;
    mem_op = NONE;
    kill   = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
